pred_check: RTL and testbench
=============================

# pred_check

Branch-prediction checker sitting directly downstream of the frontend predictor. Records, in fetch order, each issued instruction's PC, instruction word and predicted next PC in a small in-flight FIFO. When execute resolves the oldest instruction, compares the actual next PC against the prediction. Emits the registered `miss`/`last_pc`/`last_instr` update triple back to the predictor, and a one-cycle redirect to fetch that flushes the FIFO.

## Interface
Parameters:
- `DEPTH`, 4, in-flight FIFO entries; power of two, ≥2.
- `CWIDTH`, 32, width of statistics counters.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  global stall; 0 freezes every register.
- `push`  in  1  fetch issues an instruction this cycle.
- `push_pc`  in  32  PC of the issued instruction.
- `push_instr`  in  32  instruction word.
- `push_pred_pc`  in  32  predicted next PC from the predictor.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `resolve_valid`  in  1  execute resolves the oldest entry.
- `resolve_next_pc`  in  32  actual next PC of that entry.
- `upd_valid`  out  1  registered; update triple valid this cycle.
- `miss`  out  1  registered; resolved prediction was wrong.
- `last_pc`  out  32  registered; PC of the resolved entry.
- `last_instr`  out  32  registered; instruction of the resolved entry.
- `redirect_valid`  out  1  registered; one-cycle fetch redirect.
- `redirect_pc`  out  32  registered; redirect target.
- `err`  out  1  sticky protocol-error flag.
- `br_count`  out  CWIDTH  resolved entries.
- `miss_count`  out  CWIDTH  mispredicted entries.

## Operation
- FIFO: circular buffer with `log2(DEPTH)`-bit head and tail pointers and a `log2(DEPTH)+1`-bit count. Pointers wrap modulo `DEPTH`.
- `full`/`empty` are decoded from the registered count.
- FSM states:
  - RUN: normal operation.
  - RECOVER: exactly one cycle, entered after a mispredict; returns to RUN unconditionally.
- In RUN with `en=1`:
  - Push accepted if `push && (!full || pop_ok)`, where `pop_ok` is a correct (non-missing) resolve in the same cycle.
  - Resolve with `!empty`:
    - Head popped.
    - `mis = (head.pred_pc != resolve_next_pc)`, full 32-bit compare.
  - Correct resolve:
    - Simultaneous push/pop when full is allowed; count unchanged.
  - Mispredicting resolve:
    - FIFO flushed: count, head and tail all become 0.
    - Any same-cycle push is dropped (not an error).
    - Next state is RECOVER.
- In RECOVER: `push` ignored (no error). `resolve_valid` sets `err` and is otherwise ignored.
- Protocol errors set `err`, which clears only on reset:
  - `resolve_valid` when empty: no pop.
  - `push` when full without a correct pop: entry dropped.
- Update outputs on a resolve:
  - `upd_valid=1`, `miss=mis`.
  - `last_pc`/`last_instr` taken from the head entry.
  - On a mispredict: `redirect_valid=1`, `redirect_pc=resolve_next_pc`.
- Outputs on a cycle with no resolve: `upd_valid`, `miss` and `redirect_valid` go to 0. `last_pc`/`last_instr`/`redirect_pc` hold their values.
- Counters: on each resolve, `br_count += 1`, and `miss_count += mis`. Both wrap modulo 2^CWIDTH.
- `en=0`: all state and outputs hold. Consumers sample pulses only when `en=1`.
- Reset values: state RUN, count/pointers 0, `empty=1`, `full=0`. Every other output is 0, including `err` and both counters. Reset mid-flush discards RECOVER and all entries.

## Timing
- Push at cycle t: entry stored at edge t; `empty`/`full` reflect it in t+1.
- Resolve at t (compare is combinational on the head): `upd_valid`/`miss`/`last_*`/`redirect_*` asserted during t+1.
- Mispredict at t:
  - `empty=1` and state RECOVER during t+1.
  - Pushes at t and t+1 are dropped.
  - First accepted push is at t+2.
- Throughput: one push and one resolve per cycle, sustained.

## Configuration
- `PRED_CHECK_STATS_EN`:
  - Defined: `br_count`/`miss_count` counters are implemented as above.
  - Undefined: no counter registers; both outputs are tied to 0. All other behaviour is identical.

## Test plan
- Reset, then push PC 0x100 (pred 0x104), then resolve 0x104 → next cycle `upd_valid=1`, `miss=0`, `last_pc=0x100`, `redirect_valid=0`, `empty=1`.
- Push 3 entries, then resolve the first with 0x200 ≠ pred 0x104 → next cycle `miss=1`, `redirect_valid=1`, `redirect_pc=0x200`, `empty=1`. Pushes in the same cycle and the next are dropped; a push two cycles later is accepted.
- Fill to `DEPTH=4` (`full=1`), then push with a correct resolve in the same cycle → count stays 4, `err=0`. Push without a resolve → dropped, `err=1`.
- `resolve_valid` on empty FIFO after reset → `err=1`, `upd_valid=0`, counters unchanged.
- Hold `en=0` for 3 cycles during pending push/resolve → all outputs and `full`/`empty` are unchanged; operation resumes when `en=1`.
- With `PRED_CHECK_STATS_EN`, 10 resolves including 3 misses → `br_count=10`, `miss_count=3`. Without the macro, both read 0.

Source files
------------

// File: rtl/pred_check.sv
// Branch-prediction checker: in-flight FIFO of issued instructions, resolve compare,
// predictor update triple and fetch redirect. Optional counters under PRED_CHECK_STATS_EN.
module pred_check #(
  parameter int DEPTH  = 4,
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              push,
  input  logic [31:0]       push_pc,
  input  logic [31:0]       push_instr,
  input  logic [31:0]       push_pred_pc,
  output logic              full,
  output logic              empty,
  input  logic              resolve_valid,
  input  logic [31:0]       resolve_next_pc,
  output logic              upd_valid,
  output logic              miss,
  output logic [31:0]       last_pc,
  output logic [31:0]       last_instr,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              err,
  output logic [CWIDTH-1:0] br_count,
  output logic [CWIDTH-1:0] miss_count
);

  // state   | meaning
  // RUN     | normal push/resolve operation
  // RECOVER | single cycle after a mispredict; pushes dropped, resolves flagged
  typedef enum logic {RUN, RECOVER} state_t;

  localparam int AW = $clog2(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pred  [DEPTH];

  logic do_pop, do_push, mis, mis_cmp, flush, set_err;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  always_ff @(posedge clk) begin
    if (!reset)  state_q <= RUN;
    else if (en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    do_pop  = 1'b0;
    do_push = 1'b0;
    mis     = 1'b0;
    flush   = 1'b0;
    set_err = 1'b0;
    mis_cmp = (mem_pred[head_q] != resolve_next_pc);
    if (en) begin
      case (state_q)
        RUN: begin
          if (resolve_valid) begin
            if (empty) set_err = 1'b1;
            else begin
              do_pop = 1'b1;
              mis    = mis_cmp;
            end
          end
          // a mispredict flushes everything, so a same-cycle push is silently lost
          if (mis) begin
            flush   = 1'b1;
            state_d = RECOVER;
          end else if (push) begin
            if (!full || do_pop) do_push = 1'b1;
            else                 set_err = 1'b1;
          end
        end
        RECOVER: begin
          state_d = RUN;
          if (resolve_valid) set_err = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem_pc[tail_q]    <= push_pc;
      mem_instr[tail_q] <= push_instr;
      mem_pred[tail_q]  <= push_pred_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      upd_valid      <= 1'b0;
      miss           <= 1'b0;
      last_pc        <= '0;
      last_instr     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      err            <= 1'b0;
    end else if (en) begin
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_pop)  head_q <= head_q + 1'b1;
        if (do_push) tail_q <= tail_q + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
      upd_valid      <= do_pop;
      miss           <= mis;
      redirect_valid <= mis;
      if (do_pop) begin
        last_pc    <= mem_pc[head_q];
        last_instr <= mem_instr[head_q];
      end
      if (mis)     redirect_pc <= resolve_next_pc;
      if (set_err) err <= 1'b1;
    end
  end

`ifdef PRED_CHECK_STATS_EN
  logic [CWIDTH-1:0] br_q, miss_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      br_q   <= '0;
      miss_q <= '0;
    end else if (do_pop) begin
      br_q <= br_q + 1'b1;
      if (mis) miss_q <= miss_q + 1'b1;
    end
  end

  assign br_count   = br_q;
  assign miss_count = miss_q;
`else
  assign br_count   = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_pred_check.sv
// Self-checking bench for pred_check: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_pred_check;
  localparam int DEPTH  = 4;
  localparam int CWIDTH = 32;
`ifdef PRED_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0, en = 1'b1, push = 1'b0, resolve_valid = 1'b0;
  logic [31:0] push_pc = '0, push_instr = '0, push_pred_pc = '0, resolve_next_pc = '0;
  logic full, empty, upd_valid, miss, redirect_valid, err;
  logic [31:0] last_pc, last_instr, redirect_pc;
  logic [CWIDTH-1:0] br_count, miss_count;

  pred_check #(.DEPTH(DEPTH), .CWIDTH(CWIDTH)) dut (
    .clk(clk), .reset(reset), .en(en), .push(push), .push_pc(push_pc),
    .push_instr(push_instr), .push_pred_pc(push_pred_pc), .full(full), .empty(empty),
    .resolve_valid(resolve_valid), .resolve_next_pc(resolve_next_pc),
    .upd_valid(upd_valid), .miss(miss), .last_pc(last_pc), .last_instr(last_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .err(err),
    .br_count(br_count), .miss_count(miss_count));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pred;
  } ent_t;

  ent_t q[$];
  bit          m_recover, m_err, m_upd, m_miss, m_rv;
  logic [31:0] m_last_pc, m_last_instr, m_rpc, m_br, m_mc;
  int n_cmp = 0, n_bad = 0;
  bit checking = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference behaviour expressed over a queue of outstanding entries.
  function automatic void model_step();
    ent_t h;
    bit mis;
    if (!reset) begin
      q.delete();
      m_recover = 0; m_err = 0; m_upd = 0; m_miss = 0; m_rv = 0;
      m_last_pc = '0; m_last_instr = '0; m_rpc = '0; m_br = '0; m_mc = '0;
    end else if (en) begin
      m_upd = 0; m_miss = 0; m_rv = 0;
      if (m_recover) begin
        m_recover = 0;
        if (resolve_valid) m_err = 1;
      end else begin
        mis = 0;
        if (resolve_valid) begin
          if (q.size() == 0) m_err = 1;
          else begin
            h = q.pop_front();
            mis = (h.pred != resolve_next_pc);
            m_upd = 1; m_miss = mis;
            m_last_pc = h.pc; m_last_instr = h.instr;
            m_br = m_br + 1;
            if (mis) begin
              m_mc = m_mc + 1;
              m_rv = 1; m_rpc = resolve_next_pc;
              q.delete();
              m_recover = 1;
            end
          end
        end
        if (push && !mis) begin
          if (q.size() < DEPTH) q.push_back('{push_pc, push_instr, push_pred_pc});
          else m_err = 1;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("upd_valid", 32'(upd_valid), 32'(m_upd));
      chk("miss", 32'(miss), 32'(m_miss));
      chk("last_pc", last_pc, m_last_pc);
      chk("last_instr", last_instr, m_last_instr);
      chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("err", 32'(err), 32'(m_err));
      chk("br_count", br_count, STATS ? m_br : 32'h0);
      chk("miss_count", miss_count, STATS ? m_mc : 32'h0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic p, input logic [31:0] pc, input logic [31:0] pred,
                       input logic rv, input logic [31:0] npc);
    push = p; push_pc = pc; push_instr = ~pc; push_pred_pc = pred;
    resolve_valid = rv; resolve_next_pc = npc;
    cyc();
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    checking = 1'b1;
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst br_count", br_count, 32'd0);

    // single correct prediction
    drive(1, 32'h100, 32'h104, 0, 0);
    drive(0, 0, 0, 1, 32'h104);
    chk("t1 upd_valid", 32'(upd_valid), 32'd1);
    chk("t1 miss", 32'(miss), 32'd0);
    chk("t1 last_pc", last_pc, 32'h100);
    chk("t1 last_instr", last_instr, ~32'h100);
    chk("t1 redirect_valid", 32'(redirect_valid), 32'd0);
    chk("t1 empty", 32'(empty), 32'd1);

    // mispredict with three entries in flight
    drive(1, 32'h100, 32'h104, 0, 0);
    drive(1, 32'h104, 32'h108, 0, 0);
    drive(1, 32'h108, 32'h10c, 0, 0);
    drive(1, 32'h300, 32'h304, 1, 32'h200);
    chk("t2 miss", 32'(miss), 32'd1);
    chk("t2 redirect_valid", 32'(redirect_valid), 32'd1);
    chk("t2 redirect_pc", redirect_pc, 32'h200);
    chk("t2 empty", 32'(empty), 32'd1);
    drive(1, 32'h400, 32'h404, 0, 0);
    chk("t2 recover drop", 32'(empty), 32'd1);
    chk("t2 recover err", 32'(err), 32'd0);
    chk("t2 redirect pulse", 32'(redirect_valid), 32'd0);
    drive(1, 32'h500, 32'h504, 0, 0);
    chk("t2 accept after", 32'(empty), 32'd0);
    drive(0, 0, 0, 1, 32'h504);

    // fill, push with correct pop at full, then overflow
    for (int i = 0; i < DEPTH; i++) drive(1, 32'h600 + 32'(4*i), 32'h604 + 32'(4*i), 0, 0);
    chk("t3 full", 32'(full), 32'd1);
    drive(1, 32'h700, 32'h704, 1, 32'h604);
    chk("t3 full kept", 32'(full), 32'd1);
    chk("t3 no err", 32'(err), 32'd0);
    chk("t3 pop pc", last_pc, 32'h600);
    drive(1, 32'h800, 32'h804, 0, 0);
    chk("t3 overflow err", 32'(err), 32'd1);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 1, 32'h608 + 32'(4*i));
    chk("t3 drained tail", last_pc, 32'h700);

    // resolve on empty
    do_reset();
    drive(0, 0, 0, 1, 32'h40);
    chk("t4 err", 32'(err), 32'd1);
    chk("t4 upd_valid", 32'(upd_valid), 32'd0);
    chk("t4 br_count", br_count, 32'd0);

    // reset landing in the recover cycle
    do_reset();
    drive(1, 32'h20, 32'h24, 0, 0);
    drive(1, 32'h24, 32'h28, 1, 32'h99);
    reset = 1'b0;
    idle();
    reset = 1'b1;
    drive(1, 32'h30, 32'h34, 0, 0);
    chk("t5 push after rst", 32'(empty), 32'd0);
    chk("t5 err cleared", 32'(err), 32'd0);

    // stall holds everything
    drive(1, 32'h900, 32'h904, 1, 32'h34);
    drive(1, 32'h904, 32'h908, 1, 32'h904);
    en = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, 32'ha00, 32'ha04, 1, 32'h908);
    chk("t6 held upd", 32'(upd_valid), 32'd1);
    chk("t6 held last_pc", last_pc, 32'h900);
    chk("t6 held empty", 32'(empty), 32'd0);
    en = 1'b1;
    drive(1, 32'ha00, 32'ha04, 1, 32'h908);
    chk("t6 resume last_pc", last_pc, 32'h904);
    // sustained push+resolve every cycle
    for (int i = 1; i < 6; i++) drive(1, 32'ha00 + 32'(4*i), 32'ha04 + 32'(4*i), 1, 32'ha00 + 32'(4*i));
    drive(0, 0, 0, 1, 32'ha18);
    chk("t6 stream last_pc", last_pc, 32'ha14);
    chk("t6 stream empty", 32'(empty), 32'd1);

    // statistics: 10 resolves, 3 misses
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'(16*i);
      drive(1, pc, pc + 4, 0, 0);
      drive(0, 0, 0, 1, ((i % 3 == 0) && i < 9) ? pc + 8 : pc + 4);
      idle();
    end
    chk("t7 br_count", br_count, STATS ? 32'd10 : 32'd0);
    chk("t7 miss_count", miss_count, STATS ? 32'd3 : 32'd0);
    chk("t7 err", 32'(err), 32'd0);

    idle();
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
